// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: controller states,
// frame header default, flag bit positions and the latched operation record.
package alu_seq_pkg;

    localparam int OP_W = 2;
    localparam logic [1:0] HDR_DEFAULT = 2'b10;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_S = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_OK,
        ST_EXEC,
        ST_CAPTURE,
        ST_REPLY
    } state_e;

    // One pending ALU operation, whichever requester it came from.
    typedef struct packed {
        logic [OP_W-1:0] sel;
        logic [3:0]      a;
        logic [3:0]      b;
        logic            src;
    } op_t;

    function automatic logic hdr_match(input logic [7:0] byte0, input logic [1:0] hdr);
        return byte0[7:6] == hdr;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous level input plus a one-cycle
// pulse on each synchronised rising edge.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], din};
        prev_d = sync_q[1];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Arbitrates the shared ALU between SPI command frames and the local confirm
// button, captures result and flags into the PWM duty register, loads the SPI reply.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int         ALU_LAT = 1,
    parameter int         TIMEOUT = 1024,
    parameter logic [1:0] HDR     = HDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ss,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [7:0]  tx_data,
    output logic        tx_load,
    input  logic        confirm,
    input  logic [1:0]  sw_select,
    input  logic [3:0]  sw_a,
    input  logic [3:0]  sw_b,
    output logic [1:0]  alu_select,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    input  logic [3:0]  alu_result,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  pwm_duty,
    output logic [3:0]  flags_q,
    output logic        result_valid,
    output logic        src_spi,
    output logic        busy,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = $clog2(ALU_LAT + 1);

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [EW-1:0]   exec_cnt_q, exec_cnt_d;
    op_t             op_q, op_d;
    logic            pending_loc_q, pending_loc_d;
    logic [3:0]      pwm_duty_q, pwm_duty_d;
    logic [3:0]      flags_d;
    logic            src_spi_q, src_spi_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [OP_W-1:0] alu_select_q, alu_select_d;
    logic [3:0]      alu_a_q, alu_a_d;
    logic [3:0]      alu_b_q, alu_b_d;
    logic            loc_edge;

    btn_edge_sync u_confirm_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (confirm),
        .rise (loc_edge)
    );

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        exec_cnt_d    = exec_cnt_q;
        op_d          = op_q;
        pending_loc_d = pending_loc_q;
        pwm_duty_d    = pwm_duty_q;
        flags_d       = flags_q;
        src_spi_d     = src_spi_q;
        frame_err_d   = frame_err_q;
        tx_data_d     = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                // An in-frame SPI byte always wins; a local request waits.
                if (rx_valid && !ss) begin
                    if (hdr_match(rx_data, HDR)) begin
                        op_d.sel = rx_data[OP_W-1:0];
                        timer_d  = '0;
                        state_d  = ST_HDR_OK;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (pending_loc_q) begin
                    op_d.sel      = sw_select;
                    op_d.a        = sw_a;
                    op_d.b        = sw_b;
                    op_d.src      = 1'b0;
                    pending_loc_d = 1'b0;
                    exec_cnt_d    = '0;
                    state_d       = ST_EXEC;
                end
            end
            ST_HDR_OK: begin
                timer_d = timer_q + TW'(1);
                if (rx_valid) begin
                    op_d.a     = rx_data[7:4];
                    op_d.b     = rx_data[3:0];
                    op_d.src   = 1'b1;
                    exec_cnt_d = '0;
                    state_d    = ST_EXEC;
                end else if (ss || timer_q == TW'(TIMEOUT - 1)) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (exec_cnt_q == EW'(ALU_LAT - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    exec_cnt_d = exec_cnt_q + EW'(1);
                end
            end
            ST_CAPTURE: begin
                pwm_duty_d = alu_result;
                flags_d    = alu_flags;
                src_spi_d  = op_q.src;
                if (op_q.src) begin
                    // Reply is prepared here so it is already stable in the REPLY cycle.
                    tx_data_d   = {alu_flags, alu_result};
                    frame_err_d = 1'b0;
                    state_d     = ST_REPLY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REPLY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (loc_edge) begin
            pending_loc_d = 1'b1;
        end
    end

    // ALU inputs only change on entry to EXEC, so the PWM path never sees glitching operands.
    always_comb begin
        alu_select_d = alu_select_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        if (state_d == ST_EXEC && state_q != ST_EXEC) begin
            alu_select_d = op_d.sel;
            alu_a_d      = op_d.a;
            alu_b_d      = op_d.b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            exec_cnt_q    <= '0;
            op_q          <= '0;
            pending_loc_q <= 1'b0;
            pwm_duty_q    <= 4'h0;
            flags_q       <= 4'h0;
            src_spi_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            tx_data_q     <= 8'h00;
            alu_select_q  <= '0;
            alu_a_q       <= 4'h0;
            alu_b_q       <= 4'h0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            exec_cnt_q    <= exec_cnt_d;
            op_q          <= op_d;
            pending_loc_q <= pending_loc_d;
            pwm_duty_q    <= pwm_duty_d;
            flags_q       <= flags_d;
            src_spi_q     <= src_spi_d;
            frame_err_q   <= frame_err_d;
            tx_data_q     <= tx_data_d;
            alu_select_q  <= alu_select_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_load      = (state_q == ST_REPLY);
    assign alu_select   = alu_select_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign pwm_duty     = pwm_duty_q;
    assign result_valid = (state_q == ST_CAPTURE);
    assign src_spi      = src_spi_q;
    assign busy         = (state_q != ST_IDLE);
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a behavioural 4-bit ALU answers the
// DUT's operands, and expected captures are queued as stimulus is driven.
module tb_alu_cmd_sequencer;

    localparam int ALU_LAT = 2;
    localparam int TIMEOUT = 32;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [3:0] flags;
        logic       src;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [3:0] last_duty = 4'h0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ss = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       confirm = 1'b0;
    logic [1:0] sw_select = 2'd0;
    logic [3:0] sw_a = 4'h0;
    logic [3:0] sw_b = 4'h0;

    logic [7:0] tx_data;
    logic       tx_load;
    logic [1:0] alu_select;
    logic [3:0] alu_a, alu_b, alu_result, alu_flags;
    logic [3:0] pwm_duty, flags_q;
    logic       result_valid, src_spi, busy, frame_err;

    always #5 clk = ~clk;

    // 0 add, 1 sub, 2 and, 3 xor; returns {Z,C,V,S,result}
    function automatic logic [7:0] alu_model(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, v;
        s = 5'd0; r = 4'h0; c = 1'b0; v = 1'b0;
        case (sel)
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            2'd1: begin
                r = a - b;
                c = (a < b);
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            2'd2:    r = a & b;
            default: r = a ^ b;
        endcase
        return {(r == 4'h0), c, v, r[3], r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_select, alu_a, alu_b);

    alu_cmd_sequencer #(
        .ALU_LAT (ALU_LAT),
        .TIMEOUT (TIMEOUT),
        .HDR     (2'b10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ss           (ss),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .confirm      (confirm),
        .sw_select    (sw_select),
        .sw_a         (sw_a),
        .sw_b         (sw_b),
        .alu_select   (alu_select),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .pwm_duty     (pwm_duty),
        .flags_q      (flags_q),
        .result_valid (result_valid),
        .src_spi      (src_spi),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    task automatic push_exp(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b, input logic src);
        logic [7:0] m;
        exp_t e;
        m = alu_model(sel, a, b);
        e.sel = sel; e.a = a; e.b = b; e.res = m[3:0]; e.flags = m[7:4]; e.src = src;
        sb.push_back(e);
    endtask

    // Drives one byte strobe; returns at the negedge after the sampling posedge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ss = 1'b0;
        rx_valid = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Waits for the next capture, pops the oldest expectation and compares.
    task automatic expect_result(input int exp_lat);
        exp_t e;
        int   waited;
        waited = 0;
        while (!result_valid && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!result_valid || sb.size() == 0) begin
            $display("FAIL result_wait: result_valid=%0b after %0d cycles, queued=%0d", result_valid, waited, sb.size());
            return;
        end
        n_pass++;
        e = sb.pop_front();
        if (exp_lat >= 0) begin
            n_checks++;
            if (waited !== exp_lat) $display("FAIL latency: got %0d required %0d", waited, exp_lat);
            else n_pass++;
        end
        n_checks++;
        if ({alu_select, alu_a, alu_b} !== {e.sel, e.a, e.b})
            $display("FAIL alu_operands: got sel=%0d a=%h b=%h required sel=%0d a=%h b=%h",
                     alu_select, alu_a, alu_b, e.sel, e.a, e.b);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({pwm_duty, flags_q, src_spi, result_valid} !== {e.res, e.flags, e.src, 1'b0})
            $display("FAIL capture: got duty=%h flags=%h src=%0b rv=%0b required duty=%h flags=%h src=%0b rv=0",
                     pwm_duty, flags_q, src_spi, result_valid, e.res, e.flags, e.src);
        else n_pass++;
        n_checks++;
        if (tx_load !== e.src) $display("FAIL tx_load: got %0b required %0b", tx_load, e.src);
        else n_pass++;
        if (e.src) begin
            n_checks++;
            if (tx_data !== {e.flags, e.res}) $display("FAIL tx_data: got %h required %h", tx_data, {e.flags, e.res});
            else n_pass++;
        end
        last_duty = e.res;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({tx_data, tx_load, alu_select, alu_a, alu_b, pwm_duty, flags_q,
             result_valid, src_spi, busy, frame_err} !== 31'd0)
            $display("FAIL %s: got tx=%h ld=%0b sel=%0d a=%h b=%h duty=%h flags=%h rv=%0b src=%0b busy=%0b ferr=%0b required all zero",
                     name, tx_data, tx_load, alu_select, alu_a, alu_b, pwm_duty, flags_q,
                     result_valid, src_spi, busy, frame_err);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle_after_reset: busy got %0b required 0", busy);
        else n_pass++;
    endtask

    task automatic test_spi_frame();
        send_byte(8'h82);
        n_checks++;
        if ({busy, alu_select} !== {1'b1, 2'd0})
            $display("FAIL hdr_ok_hold: got busy=%0b sel=%0d required busy=1 sel=0", busy, alu_select);
        else n_pass++;
        push_exp(2'd2, 4'h3, 4'h5, 1'b1);
        send_byte(8'h35);
        n_checks++;
        if ({alu_select, alu_a, alu_b} !== {2'd2, 4'h3, 4'h5})
            $display("FAIL exec_operands: got sel=%0d a=%h b=%h required sel=2 a=3 b=5", alu_select, alu_a, alu_b);
        else n_pass++;
        expect_result(ALU_LAT);
        ss = 1'b1;
        // Add with carry out and zero result.
        push_exp(2'd0, 4'hF, 4'h1, 1'b1);
        send_byte(8'h80);
        send_byte(8'hF1);
        expect_result(ALU_LAT);
        ss = 1'b1;
        n_checks++;
        if (frame_err !== 1'b0) $display("FAIL no_frame_err: got %0b required 0", frame_err);
        else n_pass++;
    endtask

    task automatic test_bad_header();
        send_byte(8'h42);
        ss = 1'b1;
        n_checks++;
        if ({frame_err, busy, pwm_duty} !== {1'b1, 1'b0, last_duty})
            $display("FAIL bad_header: got ferr=%0b busy=%0b duty=%h required ferr=1 busy=0 duty=%h",
                     frame_err, busy, pwm_duty, last_duty);
        else n_pass++;
        push_exp(2'd1, 4'h7, 4'h4, 1'b1);
        send_byte(8'h81);
        send_byte(8'h74);
        n_checks++;
        if (frame_err !== 1'b1) $display("FAIL frame_err_sticky: got %0b required 1", frame_err);
        else n_pass++;
        expect_result(ALU_LAT);
        ss = 1'b1;
        n_checks++;
        if (frame_err !== 1'b0) $display("FAIL frame_err_cleared: got %0b required 0", frame_err);
        else n_pass++;
    endtask

    task automatic test_aborts();
        send_byte(8'h81);
        ss = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, frame_err, pwm_duty} !== {1'b0, 1'b1, last_duty})
            $display("FAIL ss_abort: got busy=%0b ferr=%0b duty=%h required busy=0 ferr=1 duty=%h",
                     busy, frame_err, pwm_duty, last_duty);
        else n_pass++;
        push_exp(2'd3, 4'h9, 4'hC, 1'b1);
        send_byte(8'h83);
        send_byte(8'h9C);
        expect_result(ALU_LAT);
        ss = 1'b1;
        send_byte(8'h80);
        repeat (TIMEOUT - 1) @(negedge clk);
        n_checks++;
        if ({busy, frame_err} !== 2'b10)
            $display("FAIL timeout_not_yet: got busy=%0b ferr=%0b required busy=1 ferr=0", busy, frame_err);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy, frame_err, pwm_duty} !== {1'b0, 1'b1, last_duty})
            $display("FAIL timeout_abort: got busy=%0b ferr=%0b duty=%h required busy=0 ferr=1 duty=%h",
                     busy, frame_err, pwm_duty, last_duty);
        else n_pass++;
        ss = 1'b1;
    endtask

    task automatic test_collision();
        sw_select = 2'd0; sw_a = 4'h9; sw_b = 4'h8;
        @(negedge clk);
        confirm = 1'b1;
        @(negedge clk);
        // The synchronised edge pulse lands in the same cycle as this byte0.
        send_byte(8'h82);
        push_exp(2'd2, 4'hE, 4'h7, 1'b1);
        push_exp(2'd0, 4'h9, 4'h8, 1'b0);
        send_byte(8'hE7);
        expect_result(ALU_LAT);
        ss = 1'b1;
        expect_result(-1);
        confirm = 1'b0;
    endtask

    task automatic test_bounce();
        int extra;
        sw_select = 2'd1; sw_a = 4'h2; sw_b = 4'h5;
        send_byte(8'h82);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            confirm = 1'b1;
            repeat (3) @(negedge clk);
            confirm = 1'b0;
            repeat (2) @(negedge clk);
        end
        push_exp(2'd2, 4'hA, 4'h6, 1'b1);
        push_exp(2'd1, 4'h2, 4'h5, 1'b0);
        send_byte(8'hA6);
        expect_result(ALU_LAT);
        ss = 1'b1;
        expect_result(-1);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (result_valid) extra++;
        end
        n_checks++;
        if (extra !== 0 || sb.size() !== 0)
            $display("FAIL bounce_single_op: got %0d extra captures, %0d queued, required 0 and 0", extra, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_exec();
        int strobes;
        send_byte(8'h80);
        send_byte(8'h11);
        n_checks++;
        if ({busy, alu_a, alu_b} !== {1'b1, 4'h1, 4'h1})
            $display("FAIL in_exec: got busy=%0b a=%h b=%h required busy=1 a=1 b=1", busy, alu_a, alu_b);
        else n_pass++;
        rst = 1'b0;
        #1;
        check_all_zero("reset_mid_exec");
        @(negedge clk);
        rst = 1'b1;
        ss = 1'b1;
        strobes = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_load || result_valid) strobes++;
        end
        n_checks++;
        if ({strobes, busy, pwm_duty} !== {32'd0, 1'b0, 4'h0})
            $display("FAIL after_reset_abort: got strobes=%0d busy=%0b duty=%h required 0 0 0", strobes, busy, pwm_duty);
        else n_pass++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_spi_frame();
        test_bad_header();
        test_aborts();
        test_collision();
        test_bounce();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
